rvga_cword_queue: RTL and testbench



---
 rtl/rvga_cword_queue_pkg.sv | 17 +
 rtl/rvga_cword_queue_ptr.sv | 25 ++
 rtl/rvga_cword_queue.sv | 113 +++++++++++
 tb/tb_rvga_cword_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvga_cword_queue_pkg.sv
// Shared widths and sizing helpers for the rvga control-word queues.
// Instantiations name their cword width through these constants.
package rvga_cword_queue_pkg;

   localparam int RVGA_EXECUTE_CWORD_W = 227;

   // Occupancy counters hold 0..DEPTH inclusive.
   function automatic int rvga_queue_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointers index 0..DEPTH-1; a single-entry queue still needs one bit.
   function automatic int rvga_queue_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/rvga_cword_queue_ptr.sv
// Wrapping pointer for a DEPTH-entry ring: counts 0..DEPTH-1 and wraps.
// Clear takes priority over increment.
module rvga_queue_ptr
   import rvga_cword_queue_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               inc,
   input  logic                               clr,
   output logic [rvga_queue_ptr_w(DEPTH)-1:0] value
);

   localparam int PW = rvga_queue_ptr_w(DEPTH);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         value <= '0;
      end else if (inc) begin
         value <= (value == PW'(DEPTH - 1)) ? '0 : value + 1'b1;
      end
   end

endmodule

// File: rtl/rvga_cword_queue.sv
// Decoupling FIFO for pipeline control words with optional empty-queue bypass,
// flush, and occupancy / high-water-mark reporting.
module rvga_cword_queue
   import rvga_cword_queue_pkg::*;
#(
   parameter int WIDTH  = RVGA_EXECUTE_CWORD_W,
   parameter int DEPTH  = 2,
   parameter int BYPASS = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   input  logic                       in_v_i,
   input  logic [WIDTH-1:0]           in_data_i,
   output logic                       in_ready_o,
   output logic                       out_v_o,
   output logic [WIDTH-1:0]           out_data_o,
   input  logic                       out_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic [$clog2(DEPTH+1)-1:0] hwm_o
);

   localparam int CW = rvga_queue_cnt_w(DEPTH);
   localparam int PW = rvga_queue_ptr_w(DEPTH);

   if (DEPTH < 1) begin : g_bad_depth
      $fatal(1, "rvga_cword_queue: DEPTH must be at least 1");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic [CW-1:0]    hwm;
   logic [CW-1:0]    hwm_nxt;
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             empty;
   logic             pass;
   logic             st_push;
   logic             st_pop;

   // Handshake: a word moves on a side only in a cycle where valid and ready
   // are both high. in_ready_o depends on registered occupancy alone, so a
   // full queue refuses a push even if the consumer pops in the same cycle.
   // out_v_o never waits on out_ready_i, and is held low during a flush.
   assign empty      = (count == '0);
   assign in_ready_o = (count < CW'(DEPTH));
   assign pass       = (BYPASS != 0) && empty && in_v_i && out_ready_i && !flush_i;

   assign out_v_o    = !flush_i && (empty ? ((BYPASS != 0) && in_v_i) : 1'b1);
   // Driving in_data_i while empty keeps the output defined before any write.
   assign out_data_o = empty ? in_data_i : mem[rptr];

   assign st_push = in_v_i && in_ready_o && !flush_i && !pass;
   assign st_pop  = out_v_o && out_ready_i && !empty;

   always_comb begin
      count_nxt = count;
      if (flush_i) begin
         count_nxt = '0;
      end else if (st_push && !st_pop) begin
         count_nxt = count + 1'b1;
      end else if (!st_push && st_pop) begin
         count_nxt = count - 1'b1;
      end
      hwm_nxt = (count_nxt > hwm) ? count_nxt : hwm;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         hwm   <= '0;
      end else begin
         count <= count_nxt;
         hwm   <= hwm_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (st_push) begin
         mem[wptr] <= in_data_i;
      end
   end

   rvga_queue_ptr #(.DEPTH(DEPTH)) u_wptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (st_push),
      .clr   (flush_i),
      .value (wptr)
   );

   rvga_queue_ptr #(.DEPTH(DEPTH)) u_rptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (st_pop),
      .clr   (flush_i),
      .value (rptr)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(st_push && count == CW'(DEPTH)))
            else $error("rvga_cword_queue: push into full queue");
         assert (!(st_pop && empty))
            else $error("rvga_cword_queue: pop from empty storage");
      end
   end

   assign count_o = count;
   assign hwm_o   = hwm;

endmodule

// File: tb/tb_rvga_cword_queue.sv
// Directed bench for rvga_cword_queue: three configurations share one stimulus
// bus; each phase resets all of them and checks the instance it targets.
module tb_rvga_cword_queue;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_v;
   logic [7:0] in_data;
   logic       out_ready;

   logic       d4_in_ready, d4_out_v;
   logic [7:0] d4_out_data;
   logic [2:0] d4_count, d4_hwm;

   logic       d3_in_ready, d3_out_v;
   logic [7:0] d3_out_data;
   logic [1:0] d3_count, d3_hwm;

   logic       by_in_ready, by_out_v;
   logic [7:0] by_out_data;
   logic [1:0] by_count, by_hwm;

   int n_vec;
   int n_err;
   logic [7:0] exp_q[$];

   typedef struct {
      logic       in_v;
      logic [7:0] data;
      logic       ordy;
      logic [2:0] count;
      logic       out_v;
      logic [7:0] odata;
      logic       rdy;
      logic [2:0] hwm;
   } vec_t;

   vec_t vecs[10];

   rvga_cword_queue #(.WIDTH(8), .DEPTH(4), .BYPASS(0)) u_d4 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_v_i(in_v), .in_data_i(in_data),
      .in_ready_o(d4_in_ready), .out_v_o(d4_out_v), .out_data_o(d4_out_data),
      .out_ready_i(out_ready), .count_o(d4_count), .hwm_o(d4_hwm)
   );

   rvga_cword_queue #(.WIDTH(8), .DEPTH(3), .BYPASS(0)) u_d3 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_v_i(in_v), .in_data_i(in_data),
      .in_ready_o(d3_in_ready), .out_v_o(d3_out_v), .out_data_o(d3_out_data),
      .out_ready_i(out_ready), .count_o(d3_count), .hwm_o(d3_hwm)
   );

   rvga_cword_queue #(.WIDTH(8), .DEPTH(2), .BYPASS(1)) u_by (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_v_i(in_v), .in_data_i(in_data),
      .in_ready_o(by_in_ready), .out_v_o(by_out_v), .out_data_o(by_out_data),
      .out_ready_i(out_ready), .count_o(by_count), .hwm_o(by_hwm)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs after the falling edge; checks follow at +1.
   task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
      @(negedge clk);
      in_v      = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_v      = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      flush     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      in_v      = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      flush     = 1'b0;

      vecs[0] = '{1'b1, 8'h0A, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 3'd0};
      vecs[1] = '{1'b1, 8'h0B, 1'b0, 3'd1, 1'b1, 8'h0A, 1'b1, 3'd1};
      vecs[2] = '{1'b1, 8'h0C, 1'b0, 3'd2, 1'b1, 8'h0A, 1'b1, 3'd2};
      vecs[3] = '{1'b1, 8'h0D, 1'b0, 3'd3, 1'b1, 8'h0A, 1'b1, 3'd3};
      vecs[4] = '{1'b1, 8'h0E, 1'b0, 3'd4, 1'b1, 8'h0A, 1'b0, 3'd4};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 8'h0A, 1'b0, 3'd4};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h0B, 1'b1, 3'd4};
      vecs[7] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h0C, 1'b1, 3'd4};
      vecs[8] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h0D, 1'b1, 3'd4};
      vecs[9] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 3'd4};

      // Reset values
      do_reset();
      chk("rst_count", 32'(d4_count), 32'd0);
      chk("rst_hwm", 32'(d4_hwm), 32'd0);
      chk("rst_out_v", 32'(d4_out_v), 32'd0);
      chk("rst_in_ready", 32'(d4_in_ready), 32'd1);
      chk("rst_by_out_v", 32'(by_out_v), 32'd0);

      // Fill/drain, DEPTH=4: fifth push refused, strict order out
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].in_v, vecs[i].data, vecs[i].ordy, 1'b0);
         chk($sformatf("fd%0d_count", i), 32'(d4_count), 32'(vecs[i].count));
         chk($sformatf("fd%0d_out_v", i), 32'(d4_out_v), 32'(vecs[i].out_v));
         chk($sformatf("fd%0d_in_ready", i), 32'(d4_in_ready), 32'(vecs[i].rdy));
         chk($sformatf("fd%0d_hwm", i), 32'(d4_hwm), 32'(vecs[i].hwm));
         if (vecs[i].out_v)
            chk($sformatf("fd%0d_data", i), 32'(d4_out_data), 32'(vecs[i].odata));
      end

      // Steady push+pop at count 2 across pointer wrap, DEPTH=3
      do_reset();
      exp_q.delete();
      drive(1'b1, 8'h01, 1'b0, 1'b0);
      exp_q.push_back(8'h01);
      drive(1'b1, 8'h02, 1'b0, 1'b0);
      exp_q.push_back(8'h02);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'(8'h03 + i), 1'b1, 1'b0);
         chk($sformatf("wr%0d_count", i), 32'(d3_count), 32'd2);
         chk($sformatf("wr%0d_out_v", i), 32'(d3_out_v), 32'd1);
         chk($sformatf("wr%0d_data", i), 32'(d3_out_data), 32'(exp_q.pop_front()));
         exp_q.push_back(8'(8'h03 + i));
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         chk($sformatf("wr_drain%0d_data", i), 32'(d3_out_data), 32'(exp_q.pop_front()));
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("wr_end_count", 32'(d3_count), 32'd0);
      chk("wr_end_hwm", 32'(d3_hwm), 32'd2);

      // Bypass on an empty queue
      do_reset();
      drive(1'b1, 8'h55, 1'b1, 1'b0);
      chk("by_pass_out_v", 32'(by_out_v), 32'd1);
      chk("by_pass_data", 32'(by_out_data), 32'h55);
      chk("by_pass_count", 32'(by_count), 32'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("by_after_count", 32'(by_count), 32'd0);
      chk("by_after_out_v", 32'(by_out_v), 32'd0);
      drive(1'b1, 8'h55, 1'b0, 1'b0);
      chk("by_stall_out_v", 32'(by_out_v), 32'd1);
      chk("by_stall_count", 32'(by_count), 32'd0);
      drive(1'b1, 8'h66, 1'b1, 1'b0);
      chk("by_store_count", 32'(by_count), 32'd1);
      chk("by_store_data", 32'(by_out_data), 32'h55);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("by_fifo_count", 32'(by_count), 32'd1);
      chk("by_fifo_data", 32'(by_out_data), 32'h66);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("by_empty_count", 32'(by_count), 32'd0);

      // Flush with a concurrent push, DEPTH=4
      do_reset();
      drive(1'b1, 8'h01, 1'b0, 1'b0);
      drive(1'b1, 8'h02, 1'b0, 1'b0);
      drive(1'b1, 8'h03, 1'b0, 1'b0);
      drive(1'b1, 8'h77, 1'b1, 1'b1);
      chk("fl_cycle_count", 32'(d4_count), 32'd3);
      chk("fl_cycle_out_v", 32'(d4_out_v), 32'd0);
      chk("fl_cycle_in_ready", 32'(d4_in_ready), 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fl_next_count", 32'(d4_count), 32'd0);
      chk("fl_next_out_v", 32'(d4_out_v), 32'd0);
      chk("fl_next_hwm", 32'(d4_hwm), 32'd3);
      drive(1'b1, 8'h44, 1'b1, 1'b0);
      chk("fl_push_out_v", 32'(d4_out_v), 32'd0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fl_head_out_v", 32'(d4_out_v), 32'd1);
      chk("fl_head_data", 32'(d4_out_data), 32'h44);

      // Reset in the middle of traffic
      do_reset();
      drive(1'b1, 8'h20, 1'b0, 1'b0);
      drive(1'b1, 8'h21, 1'b0, 1'b0);
      @(negedge clk);
      rst_n   = 1'b0;
      in_v    = 1'b1;
      in_data = 8'h22;
      @(negedge clk);
      rst_n = 1'b1;
      in_v  = 1'b0;
      #1;
      chk("mr_count", 32'(d4_count), 32'd0);
      chk("mr_hwm", 32'(d4_hwm), 32'd0);
      chk("mr_out_v", 32'(d4_out_v), 32'd0);
      chk("mr_in_ready", 32'(d4_in_ready), 32'd1);
      drive(1'b1, 8'h11, 1'b0, 1'b0);
      drive(1'b1, 8'h12, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("mr_first_data", 32'(d4_out_data), 32'h11);
      chk("mr_first_count", 32'(d4_count), 32'd2);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("mr_second_data", 32'(d4_out_data), 32'h12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
